chan_mux_scan: RTL and testbench
================================

Name: chan_mux_scan

Overview:
Parametrised N:1, W-bit channel selector. It is the sequential successor to the team's 2:1 and 4:1 combinational muxes.
- Registered output with a valid/ready handshake.
- Two modes: manual select, or automatic round-robin scan with a programmable dwell.
- Sits between multi-channel sample sources and a single downstream consumer, for example a display or serial link.

Parameters:
WIDTH, 8, bits per channel.
CHANNELS, 4, number of input channels (legal range 2..16).
SEL_W, $clog2(CHANNELS), width of the select and channel index (derived; not overridden).
DWELL_W, 4, width of the dwell count.

Ports:
clk  in  1  single rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  block enable; 0 means no new beats are produced.
mode  in  1  0 = manual (use sel_in); 1 = scan (internal counter).
sel_in  in  SEL_W  manual channel select.
dwell  in  DWELL_W  beats per channel in scan mode; 0 is treated as 1.
data_in  in  CHANNELS*WIDTH  packed channels; channel k is at bits [k*WIDTH +: WIDTH].
out_data  out  WIDTH  registered selected data.
out_sel  out  SEL_W  channel index that out_data came from.
out_valid  out  1  out_data/out_sel hold a beat.
out_ready  in  1  downstream accepts the beat.
sel_err  out  1  one-cycle pulse when a manual sel_in >= CHANNELS is loaded.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_data, out_sel, out_valid and sel_err = 0.
  - Scan channel counter = 0; dwell counter = 0; FSM = IDLE.
- Load condition: load = en & (!out_valid | out_ready).
  - On load, out_data/out_sel register the selected channel.
  - out_valid = 1 on the next edge, giving 1 cycle of latency from input to output.
- Handshake:
  - While out_valid & !out_ready, out_data and out_sel are held stable.
  - A beat completes on a cycle with out_valid & out_ready.
  - With out_ready held at 1, one beat is produced per cycle (full throughput).
- FSM states:
  - IDLE: out_valid = 0. Move to RUN when en = 1.
  - RUN: a load occurs on each cycle that the load condition is true.
    - Move to STALL when out_valid & !out_ready.
    - Move to DRAIN when en = 0.
  - STALL: hold the output. Return to RUN on out_ready.
  - DRAIN: when out_valid = 0 or out_ready = 1, clear out_valid and go to IDLE. The pending beat is still offered until accepted.
- Manual mode:
  - The channel is sel_in sampled at the load edge.
  - If sel_in >= CHANNELS, channel 0 is loaded, out_sel = 0, and sel_err pulses for 1 cycle.
- Scan mode:
  - Each load uses the scan counter channel, and the dwell counter increments.
  - When dwell count = max(dwell,1)-1, the dwell counter clears and the channel advances.
  - The channel wraps from CHANNELS-1 to 0.
  - The counters do not advance on cycles without a load.
- Mode change:
  - Switching mode takes effect on the next load.
  - Entering scan resets the dwell counter but keeps the channel counter.
- Simultaneous events:
  - An accepted beat and a load in the same cycle replace the data without a bubble.
  - en falling while STALL: the held beat stays valid until accepted, then the block goes to IDLE.
- Reset asserted mid-beat clears the output immediately; the beat is lost.

Optional Feature:
CHAN_MUX_PARITY_EN:
- When defined:
  - Adds output out_parity (1 bit): registered even parity (XOR) of the loaded data, updated with out_data. Reset value 0.
  - Adds an internal parity check for the bench.
- When undefined: the port and its logic are absent; nothing else changes.

Decomposition:
Package chan_mux_pkg contains:
- Enum typedef state_t {IDLE, RUN, STALL, DRAIN}.
- Constants MODE_MANUAL = 1'b0 and MODE_SCAN = 1'b1.
- Function clog2 for SEL_W.

One natural sub-module, chan_mux_scan_ctr:
- Holds the scan channel and dwell counters.
- Inputs: advance, dwell, clear.
- Output: channel index.
The datapath mux (indexed part-select) stays in the top module.

Test Plan:
1. Reset/idle: rst_n=0 mid-run with out_valid=1 -> out_valid, out_data, out_sel and sel_err are 0 asynchronously; after release with en=0, out_valid stays 0.
2. Manual with CHANNELS=4, data_in={8'hDD,8'hCC,8'hBB,8'hAA}, sel_in=2, en=1, out_ready=1 -> one cycle later out_data=8'hCC, out_sel=2, out_valid=1 every cycle.
3. Backpressure: as in scenario 2, drop out_ready for 3 cycles while sel_in changes to 3 -> out_data holds 8'hCC; the cycle after out_ready=1, out_data=8'hDD.
4. Scan with dwell=2, out_ready=1 -> out_sel sequence 0,0,1,1,2,2,3,3,0; with dwell=0 the sequence is 0,1,2,3,0.
5. Bad select with CHANNELS=3, manual, sel_in=3 -> out_sel=0, out_data=channel 0, and sel_err high for exactly 1 cycle.
6. Drain: scan running, en=0 while stalled -> the beat is held until out_ready, then out_valid=0 and FSM=IDLE. Parity build: out_data=8'h07 gives out_parity=1.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared types and helpers for the chan_mux_scan channel selector.
package chan_mux_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bounded so the shift never reaches the sign bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 30; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/chan_mux_scan_ctr.sv
// Scan channel / dwell counters for chan_mux_scan; chan is the channel the current load uses.
module chan_mux_scan_ctr
  import chan_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2(CHANNELS),
  parameter int DWELL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   chan
);

  logic [DWELL_W-1:0] dcnt, dcnt_eff, dlim;

  // A clear coinciding with an advance counts that load as the first beat of the dwell.
  assign dcnt_eff = clear ? '0 : dcnt;
  assign dlim     = (dwell == '0) ? '0 : dwell - 1'b1;

  // >= rather than == so a dwell shrunk mid-scan still advances on the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan <= '0;
      dcnt <= '0;
    end else if (advance) begin
      if (dcnt_eff >= dlim) begin
        dcnt <= '0;
        chan <= (chan == SEL_W'(CHANNELS - 1)) ? '0 : chan + 1'b1;
      end else begin
        dcnt <= dcnt_eff + 1'b1;
      end
    end else if (clear) begin
      dcnt <= '0;
    end
  end

endmodule

// File: rtl/chan_mux_scan.sv
// N:1 registered channel selector with valid/ready output, manual or round-robin scan select.
// Optional CHAN_MUX_PARITY_EN adds out_parity (even parity of out_data).
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = clog2(CHANNELS),
  parameter int DWELL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef CHAN_MUX_PARITY_EN
  output logic                      out_parity,
`endif
  output logic                      sel_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } beat_t;

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] chans;
  state_t           state_q, state_d;
  beat_t            beat_q;
  logic             load, scan, bad_sel, advance, clear, last_mode;
  logic [SEL_W-1:0] scan_ch, pick;

  assign chans   = data_in;
  assign load    = en & (~out_valid | out_ready);
  assign scan    = (mode == MODE_SCAN);
  assign bad_sel = ({1'b0, sel_in} >= CH_LIM);
  assign advance = load & scan;
  // Entering scan restarts the dwell but keeps the channel position.
  assign clear   = load & scan & (last_mode == MODE_MANUAL);
  assign pick    = scan ? scan_ch : (bad_sel ? '0 : sel_in);

  chan_mux_scan_ctr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL_W  (DWELL_W)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .clear   (clear),
    .dwell   (dwell),
    .chan    (scan_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
               else if (out_valid & ~out_ready) state_d = STALL;
      STALL:   if (!en) state_d = DRAIN;
               else if (out_ready) state_d = RUN;
      DRAIN:   if (~out_valid | out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A load in the same cycle as an accept replaces the beat with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      last_mode <= MODE_MANUAL;
    end else begin
      sel_err <= load & ~scan & bad_sel;
      if (load) begin
        beat_q    <= '{data: chans[pick], sel: pick};
        out_valid <= 1'b1;
        last_mode <= mode;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = beat_q.data;
  assign out_sel  = beat_q.sel;

`ifdef CHAN_MUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_parity <= 1'b0;
    else if (load) out_parity <= ^chans[pick];
  end

  a_parity: assert property (@(posedge clk) disable iff (!rst_n) out_parity == ^beat_q.data);
`endif

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan: 4-channel and 3-channel instances share control inputs.
module tb_chan_mux_scan;
  import chan_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, out_ready;
  logic [3:0]  dwell;
  logic [1:0]  sel4, sel3;
  logic [31:0] data4;
  logic [23:0] data3;
  logic [7:0]  od4, od3;
  logic [1:0]  os4, os3;
  logic        ov4, ov3, se4, se3;
`ifdef CHAN_MUX_PARITY_EN
  logic        op4, op3;
`endif

  int checks = 0;
  int errors = 0;

  int         seq2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int         seq0 [5] = '{0, 1, 2, 3, 0};
  logic [7:0] b4   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  always #5 clk = ~clk;

  chan_mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel4), .dwell(dwell),
    .data_in(data4), .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(out_ready),
`ifdef CHAN_MUX_PARITY_EN
    .out_parity(op4),
`endif
    .sel_err(se4)
  );

  chan_mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel3), .dwell(dwell),
    .data_in(data3), .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(out_ready),
`ifdef CHAN_MUX_PARITY_EN
    .out_parity(op3),
`endif
    .sel_err(se3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = MODE_MANUAL; out_ready = 1'b0;
    dwell = 4'd0; sel4 = 2'd0; sel3 = 2'd1;
    data4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    data3 = {8'h33, 8'h22, 8'h11};
    #1;
    chk("rst_valid", ov4, 0);
    chk("rst_data", od4, 0);
    #21 rst_n = 1'b1;
    step(2);
    chk("idle_valid", ov4, 0);
    chk("idle_err", se4, 0);

    // manual select
    sel4 = 2'd2; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("man_data", od4, 8'hCC);
      chk("man_sel", os4, 2);
      chk("man_valid", ov4, 1);
    end
    chk("man3_data", od3, 8'h22);

`ifdef CHAN_MUX_PARITY_EN
    data4[23:16] = 8'h07;
    step();
    chk("par_07", op4, 1);
    chk("par_07_data", od4, 8'h07);
    data4[23:16] = 8'hCC;
    step();
    chk("par_cc", op4, 0);
`endif

    // backpressure
    out_ready = 1'b0; sel4 = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", od4, 8'hCC);
      chk("bp_hold_sel", os4, 2);
      chk("bp_valid", ov4, 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_new_data", od4, 8'hDD);
    chk("bp_new_sel", os4, 3);

    // scan, dwell 2 then dwell 0
    mode = MODE_SCAN; dwell = 4'd2;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("scan_d2_sel", os4, seq2[i]);
      chk("scan_d2_data", od4, b4[seq2[i]]);
    end
    dwell = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("scan_d0_sel", os4, seq0[i]);
    end

    // bad select on 3-channel instance
    mode = MODE_MANUAL; sel3 = 2'd1;
    step();
    chk("bad_pre_err", se3, 0);
    sel3 = 2'd3;
    step();
    chk("bad_sel", os3, 0);
    chk("bad_data", od3, 8'h11);
    chk("bad_err", se3, 1);
    sel3 = 2'd1;
    step();
    chk("bad_err_clr", se3, 0);
    chk("bad_after_sel", os3, 1);
    chk("bad_after_data", od3, 8'h22);

    // drain from stall; scan counter sits at channel 1
    mode = MODE_SCAN; dwell = 4'd0;
    step();
    chk("drn_sel", os4, 1);
    chk("drn_data", od4, 8'hBB);
    out_ready = 1'b0;
    step();
    chk("drn_stall_sel", os4, 1);
    en = 1'b0;
    step(2);
    chk("drn_hold_valid", ov4, 1);
    chk("drn_hold_data", od4, 8'hBB);
    chk("drn_fsm", 32'(dut4.state_q), 32'(DRAIN));
    out_ready = 1'b1;
    step();
    chk("drn_done_valid", ov4, 0);
    chk("drn_fsm_idle", 32'(dut4.state_q), 32'(IDLE));
    step();
    chk("drn_idle_valid", ov4, 0);

    // async reset mid-beat
    en = 1'b1; mode = MODE_MANUAL; sel3 = 2'd3;
    step();
    chk("mr_pre_valid", ov4, 1);
    chk("mr_pre_err", se3, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_valid", ov4, 0);
    chk("mr_data", od4, 0);
    chk("mr_sel", os4, 0);
    chk("mr_err", se3, 0);
    chk("mr_valid3", ov3, 0);
    en = 1'b0;
    #2 rst_n = 1'b1;
    step(3);
    chk("mr_post_valid", ov4, 0);
    chk("mr_post_valid3", ov3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
